// File: rtl/rv_ctrl_alu_stage.sv
// RV32 decode-and-execute slice: main decoder, ALU-control decoder and ALU.
// All outputs are registered with one cycle of latency.
module rv_ctrl_alu_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [XLEN-1:0] imm_ext,
   output logic            out_valid,
   output logic            regwrite,
   output logic            alusrc,
   output logic            memwrite,
   output logic [1:0]      resultsrc,
   output logic [2:0]      imm_src,
   output logic            branch,
   output logic            jump,
   output logic [2:0]      alu_control,
   output logic [XLEN-1:0] alu_result,
   output logic            zero,
   output logic            illegal
);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_LUI  = 7'b0110111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       f7b5;
   logic       op5;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign f7b5   = instr[30];
   assign op5    = instr[5];

   logic       regwrite_d;
   logic       alusrc_d;
   logic       memwrite_d;
   logic [1:0] resultsrc_d;
   logic [2:0] imm_src_d;
   logic       branch_d;
   logic       jump_d;
   logic       illegal_d;
   logic [1:0] alu_op;

   always_comb begin
      regwrite_d  = 1'b0;
      alusrc_d    = 1'b0;
      memwrite_d  = 1'b0;
      resultsrc_d = 2'b00;
      imm_src_d   = 3'b000;
      branch_d    = 1'b0;
      jump_d      = 1'b0;
      illegal_d   = 1'b0;
      alu_op      = 2'b00;
      unique case (opcode)
         OP_LW: begin
            regwrite_d  = 1'b1;
            alusrc_d    = 1'b1;
            resultsrc_d = 2'b01;
         end
         OP_SW: begin
            imm_src_d  = 3'b001;
            alusrc_d   = 1'b1;
            memwrite_d = 1'b1;
         end
         OP_R: begin
            regwrite_d = 1'b1;
            alu_op     = 2'b10;
         end
         OP_I: begin
            regwrite_d = 1'b1;
            alusrc_d   = 1'b1;
            alu_op     = 2'b10;
         end
         OP_BEQ: begin
            imm_src_d = 3'b010;
            branch_d  = 1'b1;
            alu_op    = 2'b01;
         end
         OP_JAL: begin
            regwrite_d  = 1'b1;
            imm_src_d   = 3'b011;
            resultsrc_d = 2'b10;
            jump_d      = 1'b1;
         end
         OP_LUI: begin
            regwrite_d  = 1'b1;
            imm_src_d   = 3'b100;
            resultsrc_d = 2'b11;
         end
         default: illegal_d = 1'b1;
      endcase
   end

   logic [2:0] alu_ctl_d;

   always_comb begin
      alu_ctl_d = ALU_ADD;
      unique case (alu_op)
         2'b01: alu_ctl_d = ALU_SUB;
         2'b10: begin
            unique case (funct3)
               // only R-type with funct7[5] subtracts; addi never does
               3'b000:  alu_ctl_d = (op5 & f7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_ctl_d = ALU_SLT;
               3'b100:  alu_ctl_d = ALU_XOR;
               3'b110:  alu_ctl_d = ALU_OR;
               3'b111:  alu_ctl_d = ALU_AND;
               default: alu_ctl_d = ALU_ADD;
            endcase
         end
         default: alu_ctl_d = ALU_ADD;
      endcase
   end

   logic [XLEN-1:0] src_b;
   logic [XLEN-1:0] result_d;

   assign src_b = alusrc_d ? imm_ext : rs2_data;

   always_comb begin
      result_d = '0;
      unique case (alu_ctl_d)
         ALU_ADD: result_d = rs1_data + src_b;
         ALU_SUB: result_d = rs1_data - src_b;
         ALU_AND: result_d = rs1_data & src_b;
         ALU_OR:  result_d = rs1_data | src_b;
         ALU_XOR: result_d = rs1_data ^ src_b;
         ALU_SLT: result_d = {{(XLEN-1){1'b0}},
                              $signed(rs1_data) < $signed(src_b)};
         default: result_d = rs1_data + src_b;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid   <= 1'b0;
         regwrite    <= 1'b0;
         alusrc      <= 1'b0;
         memwrite    <= 1'b0;
         resultsrc   <= 2'b00;
         imm_src     <= 3'b000;
         branch      <= 1'b0;
         jump        <= 1'b0;
         alu_control <= 3'b000;
         alu_result  <= '0;
         zero        <= 1'b0;
         illegal     <= 1'b0;
      end else begin
         out_valid   <= in_valid;
         regwrite    <= in_valid & regwrite_d;
         alusrc      <= in_valid & alusrc_d;
         memwrite    <= in_valid & memwrite_d;
         resultsrc   <= in_valid ? resultsrc_d : 2'b00;
         imm_src     <= in_valid ? imm_src_d : 3'b000;
         branch      <= in_valid & branch_d;
         jump        <= in_valid & jump_d;
         alu_control <= in_valid ? alu_ctl_d : 3'b000;
         alu_result  <= result_d;
         zero        <= (result_d == '0);
         illegal     <= in_valid & illegal_d;
      end
   end

endmodule

// File: tb/tb_rv_ctrl_alu_stage.sv
// Bench for rv_ctrl_alu_stage: directed vector table, random vectors
// against a reference model, and reset corner cases.
module tb_rv_ctrl_alu_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [31:0] instr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [31:0] imm_ext;
   logic        out_valid;
   logic        regwrite;
   logic        alusrc;
   logic        memwrite;
   logic [1:0]  resultsrc;
   logic [2:0]  imm_src;
   logic        branch;
   logic        jump;
   logic [2:0]  alu_control;
   logic [31:0] alu_result;
   logic        zero;
   logic        illegal;

   always #5 clk = ~clk;

   rv_ctrl_alu_stage #(.XLEN(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .imm_ext(imm_ext),
      .out_valid(out_valid), .regwrite(regwrite), .alusrc(alusrc),
      .memwrite(memwrite), .resultsrc(resultsrc), .imm_src(imm_src),
      .branch(branch), .jump(jump), .alu_control(alu_control),
      .alu_result(alu_result), .zero(zero), .illegal(illegal)
   );

   typedef struct {
      logic        v;
      logic        rw;
      logic        as;
      logic        mw;
      logic [1:0]  rs;
      logic [2:0]  is;
      logic        br;
      logic        j;
      logic [2:0]  ac;
      logic [31:0] res;
      logic        z;
      logic        il;
   } exp_t;

   typedef struct {
      string       name;
      logic        valid;
      logic [31:0] ins;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      bit          chk_res;
      exp_t        e;
   } vec_t;

   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      total_cnt++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", n, act, exp);
      else
         pass_cnt++;
   endtask

   task automatic compare(string tag, exp_t e, bit chk_res);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(e.v));
      chk({tag, ".regwrite"}, 32'(regwrite), 32'(e.rw));
      chk({tag, ".alusrc"}, 32'(alusrc), 32'(e.as));
      chk({tag, ".memwrite"}, 32'(memwrite), 32'(e.mw));
      chk({tag, ".resultsrc"}, 32'(resultsrc), 32'(e.rs));
      chk({tag, ".imm_src"}, 32'(imm_src), 32'(e.is));
      chk({tag, ".branch"}, 32'(branch), 32'(e.br));
      chk({tag, ".jump"}, 32'(jump), 32'(e.j));
      chk({tag, ".alu_control"}, 32'(alu_control), 32'(e.ac));
      chk({tag, ".illegal"}, 32'(illegal), 32'(e.il));
      if (chk_res) begin
         chk({tag, ".alu_result"}, alu_result, e.res);
         chk({tag, ".zero"}, 32'(zero), 32'(e.z));
      end
   endtask

   // Reference model: classify the instruction, then evaluate it
   // arithmetically.
   typedef enum {K_LW, K_SW, K_R, K_I, K_BEQ, K_JAL, K_LUI, K_BAD} kind_t;
   typedef enum {O_ADD, O_SUB, O_AND, O_OR, O_XOR, O_SLT} aop_t;

   function automatic exp_t model(logic valid, logic [31:0] ins,
                                  logic [31:0] a, logic [31:0] b,
                                  logic [31:0] imm);
      exp_t  e;
      kind_t k;
      aop_t  op;
      logic [31:0] opb;
      logic [2:0] f3;
      f3 = ins[14:12];
      e = '{default: '0};
      case (ins[6:0])
         7'h03:   k = K_LW;
         7'h23:   k = K_SW;
         7'h33:   k = K_R;
         7'h13:   k = K_I;
         7'h63:   k = K_BEQ;
         7'h6F:   k = K_JAL;
         7'h37:   k = K_LUI;
         default: k = K_BAD;
      endcase
      op = O_ADD;
      if (k == K_BEQ) op = O_SUB;
      if (k == K_R || k == K_I) begin
         if (f3 == 3'd0 && k == K_R && ins[30]) op = O_SUB;
         else if (f3 == 3'd2) op = O_SLT;
         else if (f3 == 3'd4) op = O_XOR;
         else if (f3 == 3'd6) op = O_OR;
         else if (f3 == 3'd7) op = O_AND;
      end
      e.as = (k == K_LW || k == K_SW || k == K_I);
      opb = e.as ? imm : b;
      case (op)
         O_ADD: e.res = a + opb;
         O_SUB: e.res = a - opb;
         O_AND: e.res = a & opb;
         O_OR:  e.res = a | opb;
         O_XOR: e.res = a ^ opb;
         O_SLT: e.res = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
      endcase
      e.z = (e.res == 32'd0);
      e.v = valid;
      if (!valid) begin
         e.as = 1'b0;
         return e;
      end
      e.rw = (k inside {K_LW, K_R, K_I, K_JAL, K_LUI});
      e.mw = (k == K_SW);
      e.rs = (k == K_LW) ? 2'b01 : (k == K_JAL) ? 2'b10 :
             (k == K_LUI) ? 2'b11 : 2'b00;
      e.is = (k == K_SW) ? 3'd1 : (k == K_BEQ) ? 3'd2 :
             (k == K_JAL) ? 3'd3 : (k == K_LUI) ? 3'd4 : 3'd0;
      e.br = (k == K_BEQ);
      e.j  = (k == K_JAL);
      e.il = (k == K_BAD);
      case (op)
         O_ADD: e.ac = 3'd0;
         O_SUB: e.ac = 3'd1;
         O_AND: e.ac = 3'd2;
         O_OR:  e.ac = 3'd3;
         O_XOR: e.ac = 3'd4;
         O_SLT: e.ac = 3'd5;
      endcase
      return e;
   endfunction

   task automatic drive(logic v, logic [31:0] i, logic [31:0] a,
                        logic [31:0] b, logic [31:0] im);
      @(negedge clk);
      in_valid = v;
      instr    = i;
      rs1_data = a;
      rs2_data = b;
      imm_ext  = im;
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t mk(logic v, logic rw, logic as, logic mw,
                               logic [1:0] rs, logic [2:0] is,
                               logic br, logic j, logic [2:0] ac,
                               logic [31:0] res, logic il);
      exp_t e;
      e.v = v; e.rw = rw; e.as = as; e.mw = mw; e.rs = rs; e.is = is;
      e.br = br; e.j = j; e.ac = ac; e.res = res;
      e.z = (res == 32'd0); e.il = il;
      return e;
   endfunction

   vec_t vecs[$];
   exp_t zero_e;

   initial begin
      zero_e = mk(0, 0, 0, 0, 2'b00, 3'd0, 0, 0, 3'd0, 32'd0, 0);
      zero_e.z = 1'b0;

      vecs.push_back('{"add", 1, 32'h002081B3, 5, 7, 0, 1,
         mk(1, 1, 0, 0, 2'b00, 3'd0, 0, 0, 3'd0, 32'd12, 0)});
      vecs.push_back('{"sub_eq", 1, 32'h402081B3, 32'h1234, 32'h1234, 0, 1,
         mk(1, 1, 0, 0, 2'b00, 3'd0, 0, 0, 3'd1, 32'd0, 0)});
      vecs.push_back('{"sub_wrap", 1, 32'h402081B3, 0, 1, 0, 1,
         mk(1, 1, 0, 0, 2'b00, 3'd0, 0, 0, 3'd1, 32'hFFFFFFFF, 0)});
      vecs.push_back('{"lui", 1, 32'h123452B7, 3, 4, 32'h12345000, 1,
         mk(1, 1, 0, 0, 2'b11, 3'd4, 0, 0, 3'd0, 32'd7, 0)});
      vecs.push_back('{"beq_taken", 1, 32'h00208063, 9, 9, 0, 1,
         mk(1, 0, 0, 0, 2'b00, 3'd2, 1, 0, 3'd1, 32'd0, 0)});
      vecs.push_back('{"beq_not", 1, 32'h00208063, 9, 8, 0, 1,
         mk(1, 0, 0, 0, 2'b00, 3'd2, 1, 0, 3'd1, 32'd1, 0)});
      vecs.push_back('{"slt_neg", 1, 32'h0020A1B3, 32'hFFFFFFFF, 1, 0, 1,
         mk(1, 1, 0, 0, 2'b00, 3'd0, 0, 0, 3'd5, 32'd1, 0)});
      vecs.push_back('{"slt_swap", 1, 32'h0020A1B3, 1, 32'hFFFFFFFF, 0, 1,
         mk(1, 1, 0, 0, 2'b00, 3'd0, 0, 0, 3'd5, 32'd0, 0)});
      vecs.push_back('{"addi_f7b5", 1, 32'h40108093, 5, 9, 32'h401, 1,
         mk(1, 1, 1, 0, 2'b00, 3'd0, 0, 0, 3'd0, 32'h406, 0)});
      vecs.push_back('{"xor", 1, 32'h0020C1B3, 32'hF0F0, 32'h0FF0, 0, 1,
         mk(1, 1, 0, 0, 2'b00, 3'd0, 0, 0, 3'd4, 32'hFF00, 0)});
      vecs.push_back('{"or", 1, 32'h0020E1B3, 32'hF000, 32'h000F, 0, 1,
         mk(1, 1, 0, 0, 2'b00, 3'd0, 0, 0, 3'd3, 32'hF00F, 0)});
      vecs.push_back('{"and", 1, 32'h0020F1B3, 32'hF0F0, 32'h0FF0, 0, 1,
         mk(1, 1, 0, 0, 2'b00, 3'd0, 0, 0, 3'd2, 32'h00F0, 0)});
      vecs.push_back('{"lw", 1, 32'h0000A183, 32'h100, 5, 32'h10, 1,
         mk(1, 1, 1, 0, 2'b01, 3'd0, 0, 0, 3'd0, 32'h110, 0)});
      vecs.push_back('{"sw", 1, 32'h0020A023, 32'h200, 5, 32'hFFFFFFFC, 1,
         mk(1, 0, 1, 1, 2'b00, 3'd1, 0, 0, 3'd0, 32'h1FC, 0)});
      vecs.push_back('{"jal", 1, 32'h008000EF, 0, 0, 8, 1,
         mk(1, 1, 0, 0, 2'b10, 3'd3, 0, 1, 3'd0, 32'd0, 0)});
      vecs.push_back('{"illegal", 1, 32'h0000007F, 1, 2, 0, 1,
         mk(1, 0, 0, 0, 2'b00, 3'd0, 0, 0, 3'd0, 32'd3, 1)});
      vecs.push_back('{"invalid", 0, 32'h0020A023, 1, 2, 3, 0,
         mk(0, 0, 0, 0, 2'b00, 3'd0, 0, 0, 3'd0, 32'd0, 0)});

      reset    = 1'b0;
      in_valid = 1'b1;
      instr    = 32'h002081B3;
      rs1_data = 32'd5;
      rs2_data = 32'd7;
      imm_ext  = 32'd9;
      repeat (2) @(posedge clk);
      #1;
      compare("reset", zero_e, 1);

      @(negedge clk);
      reset = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].valid, vecs[i].ins, vecs[i].a, vecs[i].b,
               vecs[i].imm);
         compare(vecs[i].name, vecs[i].e, vecs[i].chk_res);
      end

      for (int n = 0; n < 300; n++) begin
         logic [6:0]  opc;
         logic [31:0] ins;
         logic        v;
         logic [31:0] a;
         logic [31:0] b;
         logic [31:0] im;
         exp_t        e;
         case ($urandom_range(0, 7))
            0: opc = 7'h03;
            1: opc = 7'h23;
            2: opc = 7'h33;
            3: opc = 7'h13;
            4: opc = 7'h63;
            5: opc = 7'h6F;
            6: opc = 7'h37;
            default: opc = 7'($urandom);
         endcase
         ins = {$urandom} & 32'hFFFFFF80;
         ins[6:0] = opc;
         v  = ($urandom_range(0, 9) != 0);
         a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) :
              $urandom;
         b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
         im = $urandom;
         drive(v, ins, a, b, im);
         e = model(v, ins, a, b, im);
         compare($sformatf("rand%0d", n), e, v);
      end

      drive(1, 32'h002081B3, 32'd5, 32'd7, 32'd0);
      chk("pre_reset.regwrite", 32'(regwrite), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      compare("async_reset", zero_e, 1);
      @(negedge clk);
      reset = 1'b1;

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/rv_ctrl_alu_stage.md
Name: rv_ctrl_alu_stage

Overview:
- Decode-and-execute slice of the single-cycle RV32 core: main control decoder, ALU-control decoder and 32-bit ALU in one block.
- Takes the fetched instruction plus operand values and produces datapath control signals, ALU result and zero flag.
- All outputs are registered, one-cycle latency, so the block can sit between decode and writeback/branch logic.

Parameters:
- XLEN, 32, datapath width. Only 32 is required to be supported.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction and operands valid this cycle
- instr  in  32  instruction word
- rs1_data  in  XLEN  register operand A
- rs2_data  in  XLEN  register operand B
- imm_ext  in  XLEN  sign-extended immediate
- out_valid  out  1  registered outputs valid
- regwrite  out  1  register-file write enable
- alusrc  out  1  1 = ALU B operand is imm_ext, 0 = rs2_data
- memwrite  out  1  data-memory write enable
- resultsrc  out  2  writeback select: 00 ALU, 01 memory, 10 PC+4, 11 immediate
- imm_src  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U
- branch  out  1  conditional branch
- jump  out  1  unconditional jump
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
- alu_result  out  XLEN  ALU result
- zero  out  1  alu_result == 0
- illegal  out  1  unsupported opcode

Behaviour:
Reset and output stage:
- reset low clears all outputs to 0 immediately: out_valid, all controls, alu_result, zero, illegal.
- On each rising clk with reset high, all outputs load from the combinational decode/ALU of the current inputs. out_valid <= in_valid.
- When in_valid=0, all control outputs load 0 and illegal loads 0. No write enables ever assert without out_valid.
- If reset asserts mid-operation, the in-flight result is discarded.

Main decoder (opcode = instr[6:0]). Any signal not listed is 0:
- 0000011 lw: regwrite=1, imm_src=000, alusrc=1, resultsrc=01, alu_op=00.
- 0100011 sw: imm_src=001, alusrc=1, memwrite=1, alu_op=00.
- 0110011 R-type: regwrite=1, alusrc=0, resultsrc=00, alu_op=10.
- 0010011 I-ALU: regwrite=1, imm_src=000, alusrc=1, alu_op=10.
- 1100011 beq: imm_src=010, branch=1, alu_op=01.
- 1101111 jal: regwrite=1, imm_src=011, resultsrc=10, jump=1.
- 0110111 lui: regwrite=1, imm_src=100, resultsrc=11.
- Any other opcode: all controls 0, illegal=1, alu_control=000.

ALU decoder (alu_op is internal; funct3=instr[14:12], f7b5=instr[30], op5=instr[5]):
- alu_op 00 -> add.
- alu_op 01 -> sub.
- alu_op 10, decoded on funct3:
  - 000: sub if op5 & f7b5, else add (so addi is never sub).
  - 010 -> slt; 100 -> xor; 110 -> or; 111 -> and.
  - Other funct3 -> add.

ALU:
- Operand A = rs1_data; operand B = alusrc ? imm_ext : rs2_data.
- add/sub: modulo 2^32, wrap-around, no overflow flag.
- and/or/xor: bitwise.
- slt: signed compare, result 1 or 0.
- zero is computed on the final result for every operation.

Test Plan:
- Reset low with nonzero inputs -> every output 0. Release reset, instr=0x002081B3 (add x3,x1,x2), rs1=5, rs2=7, in_valid=1 -> next edge: out_valid=1, regwrite=1, alusrc=0, alu_control=000, alu_result=12, zero=0.
- instr=0x402081B3 (sub), rs1=rs2=0x1234 -> alu_control=001, alu_result=0, zero=1. Same with rs1=0, rs2=1 -> alu_result=0xFFFFFFFF.
- instr=0x123452B7 (lui x5,0x12345) -> regwrite=1, resultsrc=11, imm_src=100, branch=0, jump=0, illegal=0.
- instr=0x00208063 (beq): rs1=rs2=9 -> branch=1, alu_control=001, zero=1; rs2=8 -> zero=0.
- slt R-type (funct3 010): rs1=0xFFFFFFFF, rs2=1 -> alu_result=1; swap operands -> 0. addi (0x00108093) with f7b5 bit forced 1 via imm -> alu_control=000, not sub.
- opcode 1111111 -> illegal=1, regwrite=memwrite=0. Then in_valid=0 -> out_valid=0, all enables 0. Assert reset mid-stream -> outputs clear asynchronously, without waiting for a clock edge.
